// File: rtl/ifd_scoreboard.sv
`default_nettype none
// ifd_scoreboard: checks decoded PDP-8 opcodes against the fetched instruction stream (rev 1.0).
// Optional sticky opcode coverage on cov_hit is built when IFD_SCOREBOARD_COV_EN is defined.
module ifd_scoreboard #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ifu_rd_req,
   input  logic [11:0]      ifu_rd_data,
   input  logic [5:0]       mem_op,
   input  logic [8:0]       mem_addr,
   input  logic [21:0]      op7_op,
   output logic [5:0]       err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] instr_count,
   output logic [4:0]       pending,
   output logic [27:0]      cov_hit
);
   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
   localparam logic [4:0]    FULL_CNT = 5'(DEPTH);
   localparam logic [7:0]    AGE_MAX  = 8'(TIMEOUT - 1);
   localparam int            HLT_BIT  = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t        state;
   logic [11:0]   fifo_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [4:0]    count;
   logic [7:0]    age;
   logic          req_q;
   logic          dec_q;
   logic          push_pend;

   logic [11:0]   head;
   logic          empty, full, halted;
   logic          dec_any, dec_rise, multi;
   logic          push_try, push_ok, overflow, halt_err;
   logic          illegal, underflow, dec_pop, mismatch, pass, timeout, pop;
   logic          mem_ok, op7_ok;
   logic [4:0]    count_next;
   logic [5:0]    err_next;

   function automatic logic [11:0] op7_code(input logic [4:0] idx);
      case (idx)
         5'd0:    op7_code = 12'o7000;
         5'd1:    op7_code = 12'o7001;
         5'd2:    op7_code = 12'o7004;
         5'd3:    op7_code = 12'o7006;
         5'd4:    op7_code = 12'o7010;
         5'd5:    op7_code = 12'o7012;
         5'd6:    op7_code = 12'o7020;
         5'd7:    op7_code = 12'o7040;
         5'd8:    op7_code = 12'o7041;
         5'd9:    op7_code = 12'o7100;
         5'd10:   op7_code = 12'o7200;
         5'd11:   op7_code = 12'o7300;
         5'd12:   op7_code = 12'o7402;
         5'd13:   op7_code = 12'o7404;
         5'd14:   op7_code = 12'o7410;
         5'd15:   op7_code = 12'o7420;
         5'd16:   op7_code = 12'o7430;
         5'd17:   op7_code = 12'o7440;
         5'd18:   op7_code = 12'o7450;
         5'd19:   op7_code = 12'o7500;
         5'd20:   op7_code = 12'o7510;
         5'd21:   op7_code = 12'o7600;
         default: op7_code = 12'o7000;
      endcase
   endfunction

   assign head     = fifo_mem[rd_ptr];
   assign empty    = (count == 5'd0);
   assign full     = (count == FULL_CNT);
   assign halted   = (state == HALT);
   assign pending  = count;

   assign dec_any  = (|mem_op) | (|op7_op);
   assign dec_rise = dec_any & ~dec_q;
   assign multi    = ($countones({mem_op, op7_op}) > 1);
   assign push_try = push_pend;

   // Legality is checked separately, so these only need to hold for one-hot decodes.
   always_comb begin
      mem_ok = 1'b0;
      op7_ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (mem_op[i] && head[11:9] == 3'(i) && head[8:0] == mem_addr)
            mem_ok = 1'b1;
      end
      if (op7_op[0] && head[11:9] == 3'o7)
         op7_ok = 1'b1;
      for (int j = 1; j < 22; j++) begin
         if (op7_op[j] && head == op7_code(5'(j)))
            op7_ok = 1'b1;
      end
   end

   assign illegal    = dec_rise & multi;
   assign underflow  = dec_rise & empty;
   assign dec_pop    = dec_rise & ~empty;
   assign mismatch   = dec_pop & ~illegal & ~(mem_ok | op7_ok);
   assign pass       = dec_pop & ~illegal & (mem_ok | op7_ok);
   assign timeout    = ~empty & ~dec_pop & (age == AGE_MAX);
   assign pop        = dec_pop | timeout;
   // A slot freed in the same cycle lets a push into a full FIFO proceed.
   assign push_ok    = push_try & ~halted & (~full | pop);
   assign overflow   = push_try & ~halted & full & ~pop;
   assign halt_err   = push_try & halted;
   assign count_next = count + {4'd0, push_ok} - {4'd0, pop};
   assign err_next   = {halt_err, timeout, underflow, overflow, mismatch, illegal};

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= ifu_rd_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         age         <= '0;
         req_q       <= 1'b0;
         dec_q       <= 1'b0;
         push_pend   <= 1'b0;
         err_pulse   <= '0;
         err_count   <= '0;
         instr_count <= '0;
      end else begin
         req_q     <= ifu_rd_req;
         dec_q     <= dec_any;
         push_pend <= ifu_rd_req & ~req_q;
         count     <= count_next;
         err_pulse <= err_next;

         if (push_ok)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;

         // Age tracks the current head only; any head change restarts it.
         if (pop || (push_ok && empty))
            age <= '0;
         else if (!empty)
            age <= age + 8'd1;

         if ((|err_next) && err_count != {CNT_W{1'b1}})
            err_count <= err_count + CNT_W'(1);
         if (pass && instr_count != {CNT_W{1'b1}})
            instr_count <= instr_count + CNT_W'(1);

         if (pass && op7_op[HLT_BIT]) begin
            state <= HALT;
         end else begin
            case (state)
               IDLE:    if (push_ok) state <= PEND;
               PEND:    if (count_next == 5'd0) state <= IDLE;
               HALT:    state <= HALT;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef IFD_SCOREBOARD_COV_EN
   logic [27:0] cov_q;

   always_ff @(posedge clk) begin
      if (!reset_n)
         cov_q <= '0;
      else if (pass)
         cov_q <= cov_q | {mem_op, op7_op};
   end

   assign cov_hit = cov_q;
`else
   assign cov_hit = 28'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifd_scoreboard.sv
`default_nettype none
// Directed self-checking bench for ifd_scoreboard at default parameters.
module tb_ifd_scoreboard;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ifu_rd_req = 1'b0;
   logic [11:0] ifu_rd_data = '0;
   logic [5:0]  mem_op = '0;
   logic [8:0]  mem_addr = '0;
   logic [21:0] op7_op = '0;
   logic [5:0]  err_pulse;
   logic [15:0] err_count;
   logic [15:0] instr_count;
   logic [4:0]  pending;
   logic [27:0] cov_hit;

   int checks = 0;
   int errors = 0;

   ifd_scoreboard dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ifu_rd_req  (ifu_rd_req),
      .ifu_rd_data (ifu_rd_data),
      .mem_op      (mem_op),
      .mem_addr    (mem_addr),
      .op7_op      (op7_op),
      .err_pulse   (err_pulse),
      .err_count   (err_count),
      .instr_count (instr_count),
      .pending     (pending),
      .cov_hit     (cov_hit)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Rising edge of req, then the word on the following cycle; returns after the push edge.
   task automatic fetch(input logic [11:0] word);
      ifu_rd_req = 1'b1;
      tick();
      ifu_rd_req  = 1'b0;
      ifu_rd_data = word;
      tick();
   endtask

   // One idle edge guarantees a fresh rising edge; returns right after the decode edge.
   task automatic decode(input logic [5:0] m, input logic [21:0] o, input logic [8:0] a);
      tick();
      mem_op   = m;
      op7_op   = o;
      mem_addr = a;
      tick();
      mem_op   = '0;
      op7_op   = '0;
      mem_addr = '0;
   endtask

   initial begin
      tick();
      tick();
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_err_pulse", 32'(err_pulse), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_instr_count", 32'(instr_count), 32'd0);
      check("rst_cov", 32'(cov_hit), 32'd0);
      reset_n = 1'b1;
      tick();

      // TAD 234 passes
      fetch(12'o1234);
      check("tad_pending_fill", 32'(pending), 32'd1);
      decode(6'b000010, 22'd0, 9'o234);
      check("tad_err", 32'(err_pulse), 32'd0);
      check("tad_instr", 32'(instr_count), 32'd1);
      check("tad_pending", 32'(pending), 32'd0);

      // CMA against 7041 mismatches
      fetch(12'o7041);
      decode(6'd0, 22'd1 << 7, 9'd0);
      check("cma_err", 32'(err_pulse), 32'b000010);
      check("cma_err_count", 32'(err_count), 32'd1);
      tick();
      check("cma_err_oneshot", 32'(err_pulse), 32'd0);

      // NOP accepts any 7xxx word, RAL needs an exact match
      fetch(12'o7777);
      decode(6'd0, 22'd1, 9'd0);
      check("nop_err", 32'(err_pulse), 32'd0);
      check("nop_instr", 32'(instr_count), 32'd2);
      fetch(12'o7004);
      decode(6'd0, 22'd1 << 2, 9'd0);
      check("ral_instr", 32'(instr_count), 32'd3);

      // DCA with a wrong operand address
      fetch(12'o3100);
      decode(6'b001000, 22'd0, 9'o101);
      check("dca_err", 32'(err_pulse), 32'b000010);
      check("dca_err_count", 32'(err_count), 32'd2);

      // Two opcode bits set: illegal, entry still popped
      fetch(12'o0005);
      decode(6'b000011, 22'd0, 9'd5);
      check("illegal_err", 32'(err_pulse), 32'b000001);
      check("illegal_pending", 32'(pending), 32'd0);
      check("illegal_err_count", 32'(err_count), 32'd3);

      // Decode with nothing outstanding
      decode(6'b000001, 22'd0, 9'd0);
      check("underflow_err", 32'(err_pulse), 32'b001000);
      check("underflow_err_count", 32'(err_count), 32'd4);

      // Fill, then overflow on the fifth fetch
      for (int i = 1; i <= 4; i++) fetch(12'(i));
      check("fill_pending", 32'(pending), 32'd4);
      check("fill_err", 32'(err_pulse), 32'd0);
      fetch(12'o0077);
      check("overflow_err", 32'(err_pulse), 32'b000100);
      check("overflow_pending", 32'(pending), 32'd4);
      check("overflow_err_count", 32'(err_count), 32'd5);

      // Push and pop on the same edge while full: no overflow, occupancy held
      tick();
      ifu_rd_req = 1'b1;
      tick();
      ifu_rd_req  = 1'b0;
      ifu_rd_data = 12'o0005;
      mem_op      = 6'b000001;
      mem_addr    = 9'd1;
      tick();
      mem_op   = '0;
      mem_addr = '0;
      check("simul_err", 32'(err_pulse), 32'd0);
      check("simul_pending", 32'(pending), 32'd4);
      check("simul_instr", 32'(instr_count), 32'd4);
      for (int i = 2; i <= 5; i++) decode(6'b000001, 22'd0, 9'(i));
      check("drain_pending", 32'(pending), 32'd0);
      check("drain_instr", 32'(instr_count), 32'd8);
      check("drain_err_count", 32'(err_count), 32'd5);

      // Timeout after sixteen cycles of head age
      fetch(12'o0000);
      for (int i = 0; i < 15; i++) tick();
      check("pre_timeout_err", 32'(err_pulse), 32'd0);
      check("pre_timeout_pending", 32'(pending), 32'd1);
      tick();
      check("timeout_err", 32'(err_pulse), 32'b010000);
      check("timeout_pending", 32'(pending), 32'd0);
      check("timeout_err_count", 32'(err_count), 32'd6);

      // HLT then a fetch in HALT
      fetch(12'o7402);
      decode(6'd0, 22'd1 << 12, 9'd0);
      check("hlt_err", 32'(err_pulse), 32'd0);
      check("hlt_instr", 32'(instr_count), 32'd9);
      fetch(12'o1234);
      check("halt_fetch_err", 32'(err_pulse), 32'b100000);
      check("halt_fetch_pending", 32'(pending), 32'd0);
      check("halt_err_count", 32'(err_count), 32'd7);
`ifdef IFD_SCOREBOARD_COV_EN
      check("cov_hlt", 32'(cov_hit[12]), 32'd1);
      check("cov_tad", 32'(cov_hit[23]), 32'd1);
`else
      check("cov_off", 32'(cov_hit), 32'd0);
`endif

      // Mid-operation reset clears HALT and the FIFO silently
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      fetch(12'o0001);
      fetch(12'o0002);
      check("pre_reset_pending", 32'(pending), 32'd2);
      reset_n = 1'b0;
      tick();
      check("midrst_pending", 32'(pending), 32'd0);
      check("midrst_err", 32'(err_pulse), 32'd0);
      check("midrst_err_count", 32'(err_count), 32'd0);
      check("midrst_instr", 32'(instr_count), 32'd0);
      reset_n = 1'b1;
      tick();
      check("post_rst_err", 32'(err_pulse), 32'd0);
      fetch(12'o1234);
      decode(6'b000010, 22'd0, 9'o234);
      check("post_rst_instr", 32'(instr_count), 32'd1);
      check("post_rst_pending", 32'(pending), 32'd0);
      check("post_rst_err_count", 32'(err_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ifd_scoreboard.md
IFD_SCOREBOARD -- requirements
Module: ifd_scoreboard

Interface
REQ-001 Parameter DEPTH, default 4: outstanding-fetch FIFO entries; legal range 2..16.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles from fetch capture to decode; legal range 1..255.
REQ-003 Parameter CNT_W, default 16: width of every counter output.
REQ-004 clk  in  1  free-running clock.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 ifu_rd_req  in  1  instruction fetch request from the decoder.
REQ-007 ifu_rd_data  in  12  fetched instruction word, valid the cycle after a rising edge of ifu_rd_req.
REQ-008 mem_op  in  6  one-hot decoded memory opcode: bit0 AND, 1 TAD, 2 ISZ, 3 DCA, 4 JMS, 5 JMP.
REQ-009 mem_addr  in  9  decoded memory operand field.
REQ-010 op7_op  in  22  one-hot decoded op7 opcode: bits 0..21 NOP, IAC, RAL, RTL, RAR, RTR, CML, CMA, CIA, CLL, CLA1, CLA_CLL, HLT, OSR, SKP, SNL, SZL, SZA, SNA, SMA, SPA, CLA2.
REQ-011 err_pulse  out  6  one-cycle error strobes: bit0 illegal, 1 mismatch, 2 overflow, 3 underflow, 4 timeout, 5 fetch-after-halt.
REQ-012 err_count  out  CNT_W  saturating total of error events.
REQ-013 instr_count  out  CNT_W  saturating count of decodes that pass the legality and correctness checks.
REQ-014 pending  out  5  current FIFO occupancy.
REQ-015 cov_hit  out  28  sticky per-opcode coverage bitmap: bits 0..21 op7 order, bits 22..27 mem_op order.

Function
REQ-016 Fetch capture: a rising edge of ifu_rd_req pushes the next-cycle ifu_rd_data into the FIFO.
REQ-017 Decode event: a rising edge of (|mem_op | |op7_op) pops the oldest FIFO entry and compares it against the decode.
REQ-018 Illegal check: more than one bit set across mem_op and op7_op raises err_pulse[0]; the entry is popped and no mismatch check is made.
REQ-019 Mem check: expected data[11:9] is 0..5 for AND..JMP and mem_addr equals data[8:0]; any difference raises err_pulse[1].
REQ-020 Op7 check (octal): NOP 7000, IAC 7001, RAL 7004, RTL 7006, RAR 7010, RTR 7012, CML 7020, CMA 7040, CIA 7041, CLL 7100, CLA1 7200, CLA_CLL 7300, HLT 7402, OSR 7404, SKP 7410, SNL 7420, SZL 7430, SZA 7440, SNA 7450, SMA 7500, SPA 7510, CLA2 7600.
REQ-021 NOP passes for any data with data[11:9]=7; every other op7 decode requires an exact 12-bit match, else err_pulse[1].
REQ-022 Overflow: a push with FIFO full is dropped and raises err_pulse[2]; occupancy is unchanged.
REQ-023 Underflow: a decode event with FIFO empty raises err_pulse[3]; no comparison is made.
REQ-024 Simultaneous push and pop in one cycle: both take effect and occupancy is unchanged; a full FIFO does not overflow in that case.
REQ-025 Timeout: an age counter for the head entry starts at 0 on its capture; when it reaches TIMEOUT it raises err_pulse[4] and the head entry is discarded.
REQ-026 The age counter restarts at 0 whenever the head entry changes.
REQ-027 FSM states: IDLE (FIFO empty), PEND (FIFO non-empty), HALT.
REQ-028 FSM transitions: IDLE->PEND on push; PEND->IDLE when the last entry is popped or discarded; any state->HALT on a passing HLT decode.
REQ-029 HALT is left only by reset; in HALT each fetch rising edge raises err_pulse[5] and the word is not pushed.
REQ-030 err_count increments by 1 per cycle with any err_pulse bit set, regardless of how many bits are set; err_count and instr_count saturate at all-ones.
REQ-031 Rising edges are detected against values registered in the previous cycle.
REQ-032 The first cycle after reset treats the previous values as 0.

Reset
REQ-033 On reset: FIFO empty; pending=0, err_pulse=0, err_count=0, instr_count=0, cov_hit=0; FSM in IDLE; age counter and edge registers cleared.
REQ-034 Reset asserted mid-operation discards all FIFO entries with no error pulses, and behaviour after release is identical to power-up.

Configuration
REQ-035 Macro IFD_SCOREBOARD_COV_EN defined: each passing decode sets its cov_hit bit, and the bit stays set until reset.
REQ-036 Macro IFD_SCOREBOARD_COV_EN undefined: cov_hit is constant 0 and no coverage storage is built.

Verification
REQ-037 Fetch 0o1234, then decode TAD with mem_addr=0o234 -> no error, instr_count=1, pending returns to 0.
REQ-038 Fetch 0o7041, then decode CMA -> err_pulse[1] for one cycle, err_count=1.
REQ-039 DEPTH=4: five fetches with no decode -> fifth raises err_pulse[2], pending=4.
REQ-040 Fetch with no decode for TIMEOUT=16 cycles -> err_pulse[4] on the 16th cycle, FSM returns to IDLE.
REQ-041 Decode with mem_op=6'b000011 -> err_pulse[0]; decode with FIFO empty -> err_pulse[3].
REQ-042 Fetch 0o7402, decode HLT, then fetch again -> err_pulse[5], pending stays 0; with IFD_SCOREBOARD_COV_EN defined, cov_hit[12]=1.
